// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) definitions: codeword layout, encoder and serializer state type.
// The same encode function serves the transmitter, the decoder and its scoreboards.
package hamming74_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    localparam int P0_BIT = 0;
    localparam int P1_BIT = 1;
    localparam int D0_BIT = 2;
    localparam int P2_BIT = 3;
    localparam int D1_BIT = 4;
    localparam int D2_BIT = 5;
    localparam int D3_BIT = 6;

    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Parity bits sit at the power-of-two Hamming positions 1, 2, 4.
    function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        cw         = '0;
        cw[D3_BIT] = d[3];
        cw[D2_BIT] = d[2];
        cw[D1_BIT] = d[1];
        cw[D0_BIT] = d[0];
        cw[P0_BIT] = d[3] ^ d[1] ^ d[0];
        cw[P1_BIT] = d[3] ^ d[2] ^ d[0];
        cw[P2_BIT] = d[3] ^ d[2] ^ d[1];
        return cw;
    endfunction

endpackage

// File: rtl/hamming74_ser.sv
// 7-bit parallel-to-serial shifter. A load is taken when idle or on the last bit,
// which gives gap-free back-to-back words.
module hamming74_ser
    import hamming74_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic [CW_W-1:0] i_word,
    output logic            o_ser,
    output logic            o_frame,
    output logic            o_busy,
    output logic            o_last,
    output logic            o_can_load_nxt,
    output ser_state_t      o_state
);

    ser_state_t      r_state;
    ser_state_t      w_state_nxt;
    logic [CW_W-1:0] r_shift;
    logic [CW_W-1:0] w_shift_nxt;
    logic [CW_W-1:0] w_shifted;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nxt;
    logic            w_last;

    assign w_last    = (r_state == SHIFT) && (r_idx == LAST_IDX);
    assign w_shifted = MSB_FIRST ? {r_shift[CW_W-2:0], 1'b0} : {1'b0, r_shift[CW_W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = i_word;
                    w_idx_nxt   = '0;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    if (i_load) begin
                        w_shift_nxt = i_word;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_shift_nxt = '0;
                        w_idx_nxt   = '0;
                    end
                end else begin
                    w_shift_nxt = w_shifted;
                    w_idx_nxt   = r_idx + 3'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_ser   = (r_state == SHIFT) && (MSB_FIRST ? r_shift[CW_W-1] : r_shift[0]);
    assign o_frame = (r_state == SHIFT) && (r_idx == 3'd0);
    assign o_busy  = (r_state == SHIFT);
    assign o_last  = w_last;
    assign o_state = r_state;
    // True when the cycle after this edge will be able to take a load.
    assign o_can_load_nxt = (w_state_nxt == IDLE) ||
                            ((r_state == SHIFT) && (r_idx == LAST_IDX - 3'd1));

endmodule

// File: rtl/hamming74_serial_tx.sv
// Hamming(7,4) transmitter: valid/ready nibble intake, encode with optional single-bit
// error injection, one-entry holding register, and a serial line with frame strobe.
module hamming74_serial_tx
    import hamming74_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        inj_pos,
    output logic              code_valid,
    output logic [CW_W-1:0]   code_out,
    output logic              ser_out,
    output logic              ser_frame,
    output logic              ser_busy,
    output logic [CNT_W-1:0]  words_sent
);

    // Handshake: a nibble transfers on a rising edge where in_valid && in_ready.
    // in_ready is a flop output and never looks at in_valid in the same cycle.
    logic             r_in_ready;
    logic             r_hold_full;
    logic [CW_W-1:0]  r_hold_word;
    logic             r_code_valid;
    logic [CW_W-1:0]  r_code_out;
    logic [CNT_W-1:0] r_words_sent;

    logic             w_accept;
    logic             w_load;
    logic             w_can_load;
    logic             w_can_load_nxt;
    logic             w_hold_nxt;
    logic             w_last;
    logic [CW_W-1:0]  w_inj_mask;
    logic [CW_W-1:0]  w_code;
    ser_state_t       w_ser_state;

    assign w_accept   = in_valid && r_in_ready;
    assign w_inj_mask = (inj_pos == 3'd0) ? '0 : (CW_W'(1) << (inj_pos - 3'd1));
    assign w_code     = hamming74_encode(in_data) ^ w_inj_mask;
    assign w_can_load = (w_ser_state == IDLE) || w_last;
    assign w_load     = r_hold_full && w_can_load;
    assign w_hold_nxt = w_accept ? 1'b1 : (w_load ? 1'b0 : r_hold_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready   <= 1'b1;
            r_hold_full  <= 1'b0;
            r_hold_word  <= '0;
            r_code_valid <= 1'b0;
            r_code_out   <= '0;
            r_words_sent <= '0;
        end else begin
            r_hold_full  <= w_hold_nxt;
            // Lookahead: ready if the holding register is empty or drains next edge.
            r_in_ready   <= !w_hold_nxt || w_can_load_nxt;
            r_code_valid <= w_accept;
            if (w_accept) begin
                r_hold_word <= w_code;
                r_code_out  <= w_code;
            end
            if (w_last) begin
                r_words_sent <= r_words_sent + 1'b1;
            end
        end
    end

    hamming74_ser #(
        .MSB_FIRST(MSB_FIRST)
    ) u_ser (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_load         (w_load),
        .i_word         (r_hold_word),
        .o_ser          (ser_out),
        .o_frame        (ser_frame),
        .o_busy         (ser_busy),
        .o_last         (w_last),
        .o_can_load_nxt (w_can_load_nxt),
        .o_state        (w_ser_state)
    );

    assign in_ready   = r_in_ready;
    assign code_valid = r_code_valid;
    assign code_out   = r_code_out;
    assign words_sent = r_words_sent;

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// Directed bench for hamming74_serial_tx: an MSB-first instance (16-bit counter) and an
// LSB-first instance (4-bit counter) driven in lockstep from the same stimulus.
module tb_hamming74_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic [2:0] inj_pos = '0;

    logic        a_in_ready, a_code_valid, a_ser_out, a_ser_frame, a_ser_busy;
    logic [6:0]  a_code_out;
    logic [15:0] a_words_sent;
    logic        b_in_ready, b_code_valid, b_ser_out, b_ser_frame, b_ser_busy;
    logic [6:0]  b_code_out;
    logic [3:0]  b_words_sent;

    int n_vec  = 0;
    int n_fail = 0;

    // Hand-computed codewords {d3,d2,d1,p2,d0,p1,p0} for nibbles 0..15.
    logic [6:0] enc_tab [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                                 7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    hamming74_serial_tx #(.MSB_FIRST(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .inj_pos(inj_pos), .code_valid(a_code_valid),
        .code_out(a_code_out), .ser_out(a_ser_out), .ser_frame(a_ser_frame),
        .ser_busy(a_ser_busy), .words_sent(a_words_sent)
    );

    hamming74_serial_tx #(.MSB_FIRST(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .inj_pos(inj_pos), .code_valid(b_code_valid),
        .code_out(b_code_out), .ser_out(b_ser_out), .ser_frame(b_ser_frame),
        .ser_busy(b_ser_busy), .words_sent(b_words_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Waits (bounded) for in_ready, then presents one nibble for exactly one edge.
    task automatic drive_word(input logic [3:0] d, input logic [2:0] p);
        int w;
        w = 0;
        while (!a_in_ready && w < 20) begin
            tick();
            w++;
        end
        n_vec++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout: ready a=%0b b=%0b, required 1", a_in_ready, b_in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        inj_pos  = p;
        tick();
        in_valid = 1'b0;
        inj_pos  = '0;
    endtask

    // Reference decoder: returns {syndrome[2:0], corrected data[3:0]}.
    function automatic logic [6:0] ref_decode(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] f;
        s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
        s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
        s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
        f = c;
        if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
        return {s, f[6], f[5], f[4], f[2]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_in_ready, a_code_valid, a_code_out, a_ser_out, a_ser_frame, a_ser_busy, a_words_sent}
            !== {1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_a: rdy=%0b cv=%0b code=%h ser=%0b fr=%0b busy=%0b ws=%0d, required 1 0 00 0 0 0 0",
                     a_in_ready, a_code_valid, a_code_out, a_ser_out, a_ser_frame, a_ser_busy, a_words_sent);
        end
        n_vec++;
        if ({b_in_ready, b_code_valid, b_code_out, b_ser_busy, b_words_sent} !== {1'b1, 1'b0, 7'h00, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_b: rdy=%0b cv=%0b code=%h busy=%0b ws=%0d, required 1 0 00 0 0",
                     b_in_ready, b_code_valid, b_code_out, b_ser_busy, b_words_sent);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_encode();
        do_reset();
        for (int d = 0; d < 16; d++) begin
            drive_word(4'(d), 3'd0);
            n_vec++;
            if ({a_code_valid, a_code_out, b_code_out} !== {1'b1, enc_tab[d], enc_tab[d]}) begin
                n_fail++;
                $display("FAIL encode_%0d: valid=%0b code a=%h b=%h, required 1 %h", d,
                         a_code_valid, a_code_out, b_code_out, enc_tab[d]);
            end
            tick();
            n_vec++;
            if (a_code_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL code_valid_pulse_%0d: valid=%0b, required 0", d, a_code_valid);
            end
        end
    endtask

    task automatic test_serial_order();
        logic [3:0] d;
        logic [6:0] cw;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            d  = (k == 0) ? 4'hB : 4'h1;
            cw = (k == 0) ? 7'h55 : 7'h07;
            drive_word(d, 3'd0);
            tick();
            for (int i = 0; i < 7; i++) begin
                n_vec++;
                if ({a_ser_out, b_ser_out, a_ser_frame, b_ser_frame, a_ser_busy, b_ser_busy}
                    !== {cw[6-i], cw[i], (i == 0), (i == 0), 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL serial_%h_bit%0d: ser a=%0b b=%0b fr a=%0b b=%0b busy=%0b, required %0b %0b %0b",
                             d, i, a_ser_out, b_ser_out, a_ser_frame, b_ser_frame, a_ser_busy,
                             cw[6-i], cw[i], (i == 0));
                end
                tick();
            end
            n_vec++;
            if ({a_words_sent, b_words_sent, a_ser_busy, a_ser_out} !== {16'd1, 4'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL serial_%h_done: ws a=%0d b=%0d busy=%0b ser=%0b, required 1 1 0 0",
                         d, a_words_sent, b_words_sent, a_ser_busy, a_ser_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  tab [3];
        logic [6:0]  cws [3];
        logic [20:0] a_bits, b_bits, a_exp, b_exp;
        logic        acc, saw_not_ready;
        int          sent, nbusy, first_busy, last_busy, nfr;
        int          fr [3];
        tab = '{4'h1, 4'hF, 4'h0};
        cws = '{7'h07, 7'h7F, 7'h00};
        for (int i = 0; i < 21; i++) begin
            a_exp[i] = cws[i / 7][6 - (i % 7)];
            b_exp[i] = cws[i / 7][i % 7];
        end
        a_bits = '0; b_bits = '0;
        sent = 0; nbusy = 0; first_busy = -1; last_busy = -1; nfr = 0;
        fr = '{-1, -1, -1};
        saw_not_ready = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_data  = tab[0];
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = in_valid && a_in_ready;
            if (!a_in_ready) saw_not_ready = 1'b1;
            tick();
            if (acc) begin
                sent++;
                if (sent == 3) in_valid = 1'b0;
                else in_data = tab[sent];
            end
            if (a_ser_busy) begin
                if (nbusy < 21) begin
                    a_bits[nbusy] = a_ser_out;
                    b_bits[nbusy] = b_ser_out;
                end
                if (a_ser_frame && nfr < 3) begin
                    fr[nfr] = cyc;
                    nfr++;
                end
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
                nbusy++;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (nbusy != 21 || last_busy - first_busy != 20) begin
            n_fail++;
            $display("FAIL b2b_busy: busy cycles=%0d span=%0d, required 21 20", nbusy, last_busy - first_busy);
        end
        n_vec++;
        if (nfr != 3 || fr[1] - fr[0] != 7 || fr[2] - fr[1] != 7 || fr[0] != first_busy) begin
            n_fail++;
            $display("FAIL b2b_frame: count=%0d at %0d %0d %0d busy_start=%0d, required 3 frames 7 apart from start",
                     nfr, fr[0], fr[1], fr[2], first_busy);
        end
        n_vec++;
        if ({a_bits, b_bits} !== {a_exp, b_exp}) begin
            n_fail++;
            $display("FAIL b2b_stream: a=%b b=%b, required a=%b b=%b", a_bits, b_bits, a_exp, b_exp);
        end
        n_vec++;
        if (saw_not_ready !== 1'b1 || sent != 3 || a_words_sent !== 16'd3) begin
            n_fail++;
            $display("FAIL b2b_flow: saw_not_ready=%0b accepted=%0d ws=%0d, required 1 3 3",
                     saw_not_ready, sent, a_words_sent);
        end
    endtask

    task automatic test_injection();
        logic [6:0] dec;
        logic [6:0] exp_cw;
        do_reset();
        for (int p = 1; p <= 7; p++) begin
            drive_word(4'h6, 3'(p));
            exp_cw = 7'h33;
            exp_cw[p-1] = ~exp_cw[p-1];
            dec = ref_decode(a_code_out);
            n_vec++;
            if ({a_code_out, b_code_out} !== {exp_cw, exp_cw}) begin
                n_fail++;
                $display("FAIL inject_%0d_code: code a=%h b=%h, required %h", p, a_code_out, b_code_out, exp_cw);
            end
            n_vec++;
            if (dec !== {3'(p), 4'h6}) begin
                n_fail++;
                $display("FAIL inject_%0d_decode: syndrome=%0d data=%h, required %0d 6", p, dec[6:4], dec[3:0], p);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [6:0] cw;
        cw = 7'h07;
        do_reset();
        drive_word(4'hB, 3'd0);
        tick();
        tick(); tick(); tick();
        n_vec++;
        if (a_ser_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre: busy=%0b, required 1", a_ser_busy);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({a_in_ready, a_code_valid, a_code_out, a_ser_out, a_ser_frame, a_ser_busy, a_words_sent}
            !== {1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL midreset_async: rdy=%0b cv=%0b code=%h ser=%0b fr=%0b busy=%0b ws=%0d, required 1 0 00 0 0 0 0",
                     a_in_ready, a_code_valid, a_code_out, a_ser_out, a_ser_frame, a_ser_busy, a_words_sent);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({a_in_ready, a_ser_busy, a_words_sent, b_words_sent} !== {1'b1, 1'b0, 16'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL midreset_release: rdy=%0b busy=%0b ws a=%0d b=%0d, required 1 0 0 0",
                     a_in_ready, a_ser_busy, a_words_sent, b_words_sent);
        end
        drive_word(4'h1, 3'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            n_vec++;
            if ({a_ser_out, a_ser_frame, a_ser_busy} !== {cw[6-i], (i == 0), 1'b1}) begin
                n_fail++;
                $display("FAIL midreset_next_bit%0d: ser=%0b fr=%0b busy=%0b, required %0b %0b 1",
                         i, a_ser_out, a_ser_frame, a_ser_busy, cw[6-i], (i == 0));
            end
            tick();
        end
        n_vec++;
        if (a_words_sent !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset_count: ws=%0d, required 1", a_words_sent);
        end
    endtask

    task automatic test_counter_wrap();
        int w;
        do_reset();
        for (int n = 0; n < 17; n++) begin
            drive_word(4'(n), 3'd0);
        end
        tick();
        tick();
        w = 0;
        while (a_ser_busy && w < 40) begin
            tick();
            w++;
        end
        n_vec++;
        if (a_ser_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_drain: busy=%0b, required 0", a_ser_busy);
        end
        n_vec++;
        if ({a_words_sent, b_words_sent} !== {16'd17, 4'd1}) begin
            n_fail++;
            $display("FAIL wrap_count: ws a=%0d b=%0d, required 17 1", a_words_sent, b_words_sent);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_encode();
        test_serial_order();
        test_back_to_back();
        test_injection();
        test_reset_mid_word();
        test_counter_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming74_serial_tx.md
Name: hamming74_serial_tx

Overview:
Transmit-side counterpart of the team's Hamming(7,4) decoder.
- Accepts 4-bit data nibbles over a valid/ready handshake and encodes each into a 7-bit codeword, using the same bit layout the decoder expects.
- Serializes each codeword onto a 1-bit line with a frame-start strobe.
- Optional single-bit error injection, so the decoder path can be exercised end to end.
- Sits between the data source and the serial channel feeding the decoder.

Parameters:
MSB_FIRST, 1, 1 = serialize bit 6 first, 0 = bit 0 first
CNT_W, 16, width of the transmitted-word counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  source has a nibble
in_ready  out  1  block can accept a nibble this cycle
in_data  in  4  data nibble d[3:0]
inj_pos  in  3  error injection, sampled with in_data; 0 = none, 1..7 = flip codeword bit (inj_pos-1)
code_valid  out  1  one-cycle pulse: code_out holds a newly encoded word
code_out  out  7  last encoded codeword, after injection
ser_out  out  1  serial data bit
ser_frame  out  1  high during the first bit of each codeword
ser_busy  out  1  serializer is shifting a word
words_sent  out  CNT_W  count of fully serialized codewords

Behaviour:
- Reset: clock is clk; reset is asynchronous, active-low on rst_n. All state clears immediately on assertion.
  - Reset values: in_ready=1, code_valid=0, code_out=0, ser_out=0, ser_frame=0, ser_busy=0, words_sent=0, holding register empty.
- Encoding: codeword = {d3, d2, d1, p2, d0, p1, p0}, where:
  - p0 = d3^d1^d0
  - p1 = d3^d2^d0
  - p2 = d3^d2^d1
  - Data sits at bits 6, 5, 4, 2; parity sits at bits 0, 1, 3.
- Injection:
  - If inj_pos != 0, bit (inj_pos-1) is XOR-inverted after encoding.
  - inj_pos is the 1-based Hamming position, so the decoder syndrome equals inj_pos.
- Accept: a handshake occurs when in_valid && in_ready.
  - On the next edge the codeword goes into a 1-entry holding register, code_out updates, and code_valid pulses for 1 cycle.
  - Latency from accept to code_valid is 1 cycle.
- in_ready = holding register empty. It is registered and must not depend combinationally on in_valid.
- Serializer states:
  - IDLE: ser_busy=0, ser_out=0.
  - Holding full and serializer IDLE: the next edge moves the word into the shift register, enters SHIFT with bit index 0, and empties the holding register.
  - SHIFT: 7 cycles, one bit per cycle. ser_frame=1 only on bit index 0. Bit order is set by MSB_FIRST.
  - After index 6:
    - If holding is full, reload back-to-back with no gap cycle; ser_frame is high on the next cycle.
    - Otherwise go to IDLE.
  - words_sent increments on the final-bit cycle of each word and wraps modulo 2^CNT_W.
- Simultaneous events:
  - An accept on the same edge the holding register empties into the shifter is legal.
  - in_ready is therefore high whenever holding is empty or is being drained that edge (registered lookahead). Sustained throughput is 1 word per 7 cycles.
- in_valid low or in_data changes while in_ready=0 have no effect.
- Mid-word reset aborts the word immediately: words_sent is not incremented and the word is lost.
- Word boundaries: ser_out is stable for the whole cycle and changes only on clk rising edges.

Decomposition:
- Shared package hamming74_pkg holds:
  - CW_W=7, DATA_W=4.
  - Bit-position constants P0_BIT=0, P1_BIT=1, D0_BIT=2, P2_BIT=3, D1_BIT=4, D2_BIT=5, D3_BIT=6.
  - A pure encode function, to be reused by the decoder and the scoreboard.
  - A serializer state enum {IDLE, SHIFT}.
- One sub-module is natural: hamming74_ser, a 7-bit parallel-to-serial shifter with load/busy/last/frame outputs. Encode and injection stay in the top module.

Test Plan:
- Encode sweep: send in_data 0..15, inj_pos=0. code_out matches the table, including 0x0->7'h00, 0xB->7'h55, 0x1->7'h07, 0xF->7'h7F. Each code_valid arrives exactly 1 cycle after accept.
- Serial order: MSB_FIRST=1, send 0xB. ser_out over 7 cycles reads 1,0,1,0,1,0,1, ser_frame is high only on the first cycle, and words_sent=1 afterwards. Repeat with MSB_FIRST=0, expecting bit 0 first.
- Back-to-back: in_valid held high with 0x1, 0xF, 0x0. ser_frame pulses exactly 7 cycles apart with no idle gap, ser_busy stays high for 21 cycles, and in_ready drops while the holding register is full.
- Injection loop: for inj_pos 1..7 send 0x6 into a decoder model. code_out equals the clean codeword XOR (1<<(inj_pos-1)), and the decoder syndrome equals inj_pos with corrected data 0x6.
- Reset mid-word: deassert rst_n at bit 3 of a word. All outputs go to reset values asynchronously, words_sent=0, in_ready=1 after release, and the next word serializes cleanly.
- Counter wrap: with CNT_W=4, send 17 words. words_sent reads 1 after the 17th.
